// File: rtl/hsid_pkg.sv
// ---------------------------------------------------------------------------
// hsid_pkg
//   Shared constants and types for the HSI library match datapath.
//   HSID_DATA_WIDTH_ACC   : width of MSE / accumulator values
//   HSID_HSI_LIBRARY_SIZE : maximum library entries per run
//   HSID_TOPK_DEFAULT     : default number of ranked slots in the top-K sorter
//   hsid_topk_state_t     : top-K sorter control states
// ---------------------------------------------------------------------------
package hsid_pkg;

    localparam int unsigned HSID_DATA_WIDTH_ACC   = 48;
    localparam int unsigned HSID_HSI_LIBRARY_SIZE = 256;
    localparam int unsigned HSID_TOPK_DEFAULT     = 4;

    typedef enum logic [1:0] {
        TK_IDLE,
        TK_COMPARE,
        TK_DONE
    } hsid_topk_state_t;

endpackage

// File: rtl/hsid_topk_slot.sv
// ---------------------------------------------------------------------------
// hsid_topk_slot
//   One ranked slot of the top-K sorter: value, library ref and valid flag.
//   Ports:
//     clk, rst      : clock, asynchronous active-high reset
//     clr_i         : synchronous invalidate (slot reads back as 0/0)
//     find_max_i    : ranking mode, 0 = smaller is better, 1 = larger is better
//     new_value_i   : candidate MSE value
//     new_ref_i     : candidate library ref
//     up_value_i, up_ref_i, up_valid_i : contents of the next-better slot
//     ins_i         : load the candidate
//     shift_i       : load the next-better slot's contents
//     value_o, ref_o, valid_o : current slot contents
//     ge_o          : slot is valid and better-or-equal to the candidate
// ---------------------------------------------------------------------------
module hsid_topk_slot #(
    parameter int unsigned ACC_WIDTH = 48,
    parameter int unsigned REF_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 find_max_i,
    input  logic [ACC_WIDTH-1:0] new_value_i,
    input  logic [REF_WIDTH-1:0] new_ref_i,
    input  logic [ACC_WIDTH-1:0] up_value_i,
    input  logic [REF_WIDTH-1:0] up_ref_i,
    input  logic                 up_valid_i,
    input  logic                 ins_i,
    input  logic                 shift_i,
    output logic [ACC_WIDTH-1:0] value_o,
    output logic [REF_WIDTH-1:0] ref_o,
    output logic                 valid_o,
    output logic                 ge_o
);

    logic [ACC_WIDTH-1:0] value_q;
    logic [REF_WIDTH-1:0] ref_q;
    logic                 valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            ref_q   <= '0;
            valid_q <= 1'b0;
        end else if (clr_i) begin
            value_q <= '0;
            ref_q   <= '0;
            valid_q <= 1'b0;
        end else if (ins_i) begin
            value_q <= new_value_i;
            ref_q   <= new_ref_i;
            valid_q <= 1'b1;
        end else if (shift_i) begin
            value_q <= up_value_i;
            ref_q   <= up_ref_i;
            valid_q <= up_valid_i;
        end
    end

    // Equality counts as better so that an earlier-accepted tie stays ahead.
    always_comb begin
        ge_o = 1'b0;
        if (valid_q) begin
            ge_o = find_max_i ? (value_q >= new_value_i) : (value_q <= new_value_i);
        end
    end

    assign value_o = value_q;
    assign ref_o   = ref_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/hsid_topk_mse_sorter.sv
// ---------------------------------------------------------------------------
// hsid_topk_mse_sorter
//   Streaming top-K selector: keeps the K best (lowest or highest) MSE
//   matches in sorted order, one entry per clock, and presents the ranked
//   list once the last library entry has been accepted.
//   Ports:
//     clk, rst        : clock, asynchronous active-high reset
//     start           : begin a run (honoured in IDLE or DONE)
//     find_max        : mode latched at start, 0 = K smallest, 1 = K largest
//     clear           : synchronous abort to IDLE, empties all slots
//     mse_valid/mse_ready/mse_value/mse_ref/mse_last : input stream
//     busy, done      : run in progress / ranked list final
//     topk_value      : K packed values, slot 0 (best) in the low bits
//     topk_ref        : K packed refs, aligned with topk_value
//     topk_count      : number of valid slots (saturates at K)
//     entry_count     : entries accepted this run (saturates at LIBRARY_SIZE)
// ---------------------------------------------------------------------------
module hsid_topk_mse_sorter
    import hsid_pkg::*;
#(
    parameter int unsigned ACC_WIDTH    = HSID_DATA_WIDTH_ACC,
    parameter int unsigned LIBRARY_SIZE = HSID_HSI_LIBRARY_SIZE,
    parameter int unsigned K            = HSID_TOPK_DEFAULT,
    parameter int unsigned REF_WIDTH    = $clog2(LIBRARY_SIZE),
    parameter int unsigned CNT_WIDTH    = $clog2(LIBRARY_SIZE + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      find_max,
    input  logic                      clear,
    input  logic                      mse_valid,
    output logic                      mse_ready,
    input  logic [ACC_WIDTH-1:0]      mse_value,
    input  logic [REF_WIDTH-1:0]      mse_ref,
    input  logic                      mse_last,
    output logic                      busy,
    output logic                      done,
    output logic [K*ACC_WIDTH-1:0]    topk_value,
    output logic [K*REF_WIDTH-1:0]    topk_ref,
    output logic [$clog2(K+1)-1:0]    topk_count,
    output logic [CNT_WIDTH-1:0]      entry_count
);

    localparam int unsigned TCW = $clog2(K + 1);

    hsid_topk_state_t     state_q, state_d;
    logic                 find_max_q, find_max_d;
    logic [TCW-1:0]       count_q, count_d;
    logic [CNT_WIDTH-1:0] entry_q, entry_d;
    logic                 clr_slots;
    logic                 accept;

    logic [K-1:0]         ge, valid, ins, shf;
    logic [K:0]           ge_prev;
    logic [ACC_WIDTH-1:0] val_w  [K];
    logic [REF_WIDTH-1:0] ref_w  [K];
    logic [ACC_WIDTH-1:0] up_val [K];
    logic [REF_WIDTH-1:0] up_ref [K];
    logic                 up_vld [K];

    // Clear outranks start and any accept in the same cycle.
    always_comb begin
        state_d    = state_q;
        find_max_d = find_max_q;
        count_d    = count_q;
        entry_d    = entry_q;
        clr_slots  = 1'b0;
        accept     = 1'b0;
        if (clear) begin
            state_d   = TK_IDLE;
            clr_slots = 1'b1;
            count_d   = '0;
            entry_d   = '0;
        end else begin
            case (state_q)
                TK_COMPARE: begin
                    accept = mse_valid;
                    if (mse_valid) begin
                        if (entry_q != CNT_WIDTH'(LIBRARY_SIZE)) entry_d = entry_q + 1'b1;
                        // Slot K-1 not better-or-equal means p < K, so the entry is kept.
                        if (!ge[K-1] && count_q != TCW'(K)) count_d = count_q + 1'b1;
                        if (mse_last) state_d = TK_DONE;
                    end
                end
                default: begin
                    if (start) begin
                        state_d    = TK_COMPARE;
                        find_max_d = find_max;
                        clr_slots  = 1'b1;
                        count_d    = '0;
                        entry_d    = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= TK_IDLE;
            find_max_q <= 1'b0;
            count_q    <= '0;
            entry_q    <= '0;
        end else begin
            state_q    <= state_d;
            find_max_q <= find_max_d;
            count_q    <= count_d;
            entry_q    <= entry_d;
        end
    end

    // Slots are sorted, so ge is a thermometer code (ones for slots 0..p-1).
    // The insert point is its single 1->0 edge; every slot below it shifts.
    assign ge_prev = {ge, 1'b1};
    always_comb begin
        ins = '0;
        shf = '0;
        for (int unsigned i = 0; i < K; i++) begin
            ins[i] = accept & ~ge[i] & ge_prev[i];
            shf[i] = accept & ~ge_prev[i];
        end
    end

    for (genvar i = 0; i < K; i++) begin : g_slot
        if (i == 0) begin : g_top
            assign up_val[i] = '0;
            assign up_ref[i] = '0;
            assign up_vld[i] = 1'b0;
        end else begin : g_rest
            assign up_val[i] = val_w[i-1];
            assign up_ref[i] = ref_w[i-1];
            assign up_vld[i] = valid[i-1];
        end

        hsid_topk_slot #(
            .ACC_WIDTH (ACC_WIDTH),
            .REF_WIDTH (REF_WIDTH)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .clr_i       (clr_slots),
            .find_max_i  (find_max_q),
            .new_value_i (mse_value),
            .new_ref_i   (mse_ref),
            .up_value_i  (up_val[i]),
            .up_ref_i    (up_ref[i]),
            .up_valid_i  (up_vld[i]),
            .ins_i       (ins[i]),
            .shift_i     (shf[i]),
            .value_o     (val_w[i]),
            .ref_o       (ref_w[i]),
            .valid_o     (valid[i]),
            .ge_o        (ge[i])
        );

        assign topk_value[i*ACC_WIDTH +: ACC_WIDTH] = val_w[i];
        assign topk_ref[i*REF_WIDTH +: REF_WIDTH]   = ref_w[i];
    end

    assign mse_ready   = (state_q == TK_COMPARE);
    assign busy        = (state_q == TK_COMPARE);
    assign done        = (state_q == TK_DONE);
    assign topk_count  = count_q;
    assign entry_count = entry_q;

endmodule

// File: tb/tb_hsid_topk_mse_sorter.sv
// ---------------------------------------------------------------------------
// tb_hsid_topk_mse_sorter
//   Bench for the top-K sorter: a K=4 instance for the ranking scenarios and
//   a K=1 instance for the long random run. Expected ranked lists come from a
//   selection-based reference model and are queued when a run is launched.
// ---------------------------------------------------------------------------
module tb_hsid_topk_mse_sorter;

    localparam int AW = 48;
    localparam int RW = 8;
    localparam int CW = 9;

    typedef struct packed {
        logic [4*AW-1:0] v;
        logic [4*RW-1:0] r;
        logic [3:0]      cnt;
        logic [CW-1:0]   ec;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // K=4 instance
    logic            a_start = 0, a_find_max = 0, a_clear = 0, a_valid = 0, a_last = 0;
    logic [AW-1:0]   a_value = '0;
    logic [RW-1:0]   a_ref   = '0;
    logic            a_ready, a_busy, a_done;
    logic [4*AW-1:0] a_topk_value;
    logic [4*RW-1:0] a_topk_ref;
    logic [2:0]      a_topk_count;
    logic [CW-1:0]   a_entry_count;

    // K=1 instance
    logic            b_start = 0, b_find_max = 0, b_clear = 0, b_valid = 0, b_last = 0;
    logic [AW-1:0]   b_value = '0;
    logic [RW-1:0]   b_ref   = '0;
    logic            b_ready, b_busy, b_done;
    logic [AW-1:0]   b_topk_value;
    logic [RW-1:0]   b_topk_ref;
    logic [0:0]      b_topk_count;
    logic [CW-1:0]   b_entry_count;

    hsid_topk_mse_sorter #(.ACC_WIDTH(AW), .LIBRARY_SIZE(256), .K(4)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .find_max(a_find_max), .clear(a_clear),
        .mse_valid(a_valid), .mse_ready(a_ready), .mse_value(a_value), .mse_ref(a_ref),
        .mse_last(a_last), .busy(a_busy), .done(a_done), .topk_value(a_topk_value),
        .topk_ref(a_topk_ref), .topk_count(a_topk_count), .entry_count(a_entry_count)
    );

    hsid_topk_mse_sorter #(.ACC_WIDTH(AW), .LIBRARY_SIZE(256), .K(1)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .find_max(b_find_max), .clear(b_clear),
        .mse_valid(b_valid), .mse_ready(b_ready), .mse_value(b_value), .mse_ref(b_ref),
        .mse_last(b_last), .busy(b_busy), .done(b_done), .topk_value(b_topk_value),
        .topk_ref(b_topk_ref), .topk_count(b_topk_count), .entry_count(b_entry_count)
    );

    int checks = 0;
    int passes = 0;
    exp_t sb_q[$];

    logic [AW-1:0] stim_v [0:255];
    logic [RW-1:0] stim_r [0:255];

    // Reference: repeatedly pick the best untaken entry; strict compare keeps
    // the earliest index first among equal values.
    function automatic exp_t model(input bit fm, input int k, input int n);
        exp_t e;
        bit   taken [0:255];
        int   best;
        e = '0;
        for (int j = 0; j < 256; j++) taken[j] = 1'b0;
        for (int s = 0; s < k && s < n; s++) begin
            best = -1;
            for (int j = 0; j < n; j++) begin
                if (!taken[j]) begin
                    if (best < 0) best = j;
                    else if (fm ? (stim_v[j] > stim_v[best]) : (stim_v[j] < stim_v[best])) best = j;
                end
            end
            taken[best] = 1'b1;
            e.v[s*AW +: AW] = stim_v[best];
            e.r[s*RW +: RW] = stim_r[best];
        end
        e.cnt = 4'((n < k) ? n : k);
        e.ec  = CW'((n < 256) ? n : 256);
        return e;
    endfunction

    task automatic load_stream6();
        logic [AW-1:0] vals [0:5];
        vals = '{48'd50, 48'd10, 48'd30, 48'd10, 48'd70, 48'd5};
        for (int j = 0; j < 6; j++) begin
            stim_v[j] = vals[j];
            stim_r[j] = RW'(j);
        end
    endtask

    task automatic start_a(input bit fm);
        @(negedge clk);
        a_start = 1; a_find_max = fm;
        @(negedge clk);
        a_start = 0; a_find_max = ~fm;
        checks++;
        if (a_busy !== 1'b1 || a_ready !== 1'b1 || a_done !== 1'b0 || a_topk_count !== 3'd0 ||
            a_entry_count !== '0 || a_topk_value !== '0 || a_topk_ref !== '0)
            $display("FAIL start_entry: busy=%b ready=%b done=%b cnt=%0d ec=%0d val=%h, required busy=1 ready=1 done=0 all zero",
                     a_busy, a_ready, a_done, a_topk_count, a_entry_count, a_topk_value);
        else passes++;
    endtask

    task automatic feed_a(input int from, input int to, input bit last_at_end);
        for (int j = from; j < to; j++) begin
            a_valid = 1; a_value = stim_v[j]; a_ref = stim_r[j];
            a_last  = last_at_end && (j == to - 1);
            checks++;
            if (a_ready !== 1'b1) $display("FAIL ready_in_compare: got %b required 1", a_ready);
            else passes++;
            @(negedge clk);
        end
        a_valid = 0; a_last = 0;
    endtask

    // Called one cycle after the last accept: done must already be high.
    task automatic check_result_a(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            $display("FAIL %s_scoreboard: queue empty, required an expected entry", name);
            return;
        end
        e = sb_q.pop_front();
        checks++;
        if (a_done !== 1'b1 || a_busy !== 1'b0) $display("FAIL %s_done: done=%b busy=%b required done=1 busy=0", name, a_done, a_busy);
        else passes++;
        checks++;
        if (a_topk_value !== e.v) $display("FAIL %s_values: got %h required %h", name, a_topk_value, e.v);
        else passes++;
        checks++;
        if (a_topk_ref !== e.r) $display("FAIL %s_refs: got %h required %h", name, a_topk_ref, e.r);
        else passes++;
        checks++;
        if (a_topk_count !== e.cnt[2:0]) $display("FAIL %s_count: got %0d required %0d", name, a_topk_count, e.cnt);
        else passes++;
        checks++;
        if (a_entry_count !== e.ec) $display("FAIL %s_entry_count: got %0d required %0d", name, a_entry_count, e.ec);
        else passes++;
    endtask

    task automatic test_reset();
        rst = 1;
        #12;
        checks++;
        if (a_busy !== 0 || a_done !== 0 || a_ready !== 0 || a_topk_value !== '0 || a_topk_ref !== '0 ||
            a_topk_count !== '0 || a_entry_count !== '0 || b_busy !== 0 || b_done !== 0 || b_ready !== 0)
            $display("FAIL reset_state: busy=%b done=%b ready=%b cnt=%0d ec=%0d required all 0",
                     a_busy, a_done, a_ready, a_topk_count, a_entry_count);
        else passes++;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_min_mode();
        load_stream6();
        sb_q.push_back(model(1'b0, 4, 6));
        start_a(1'b0);
        feed_a(0, 6, 1'b1);
        check_result_a("min6");
        // Fixed spot check of the ranked list from a hand-worked example.
        checks++;
        if (a_topk_value[AW-1:0] !== 48'd5 || a_topk_ref[RW-1:0] !== 8'd5 || a_topk_ref[3*RW +: RW] !== 8'd2)
            $display("FAIL min6_known: slot0=%0d/%0d slot3 ref=%0d required 5/5 and ref 2",
                     a_topk_value[AW-1:0], a_topk_ref[RW-1:0], a_topk_ref[3*RW +: RW]);
        else passes++;
        // done holds in DONE while no start arrives
        repeat (3) @(negedge clk);
        checks++;
        if (a_done !== 1'b1 || a_topk_count !== 3'd4) $display("FAIL done_hold: done=%b cnt=%0d required 1/4", a_done, a_topk_count);
        else passes++;
    endtask

    task automatic test_max_mode();
        load_stream6();
        sb_q.push_back(model(1'b1, 4, 6));
        start_a(1'b1);
        feed_a(0, 6, 1'b1);
        check_result_a("max6");
    endtask

    task automatic test_partial();
        stim_v[0] = 48'd9; stim_r[0] = 8'd7;
        stim_v[1] = 48'd3; stim_r[1] = 8'd8;
        sb_q.push_back(model(1'b0, 4, 2));
        start_a(1'b0);
        feed_a(0, 2, 1'b1);
        check_result_a("partial2");
    endtask

    task automatic test_clear();
        load_stream6();
        start_a(1'b0);
        feed_a(0, 2, 1'b0);
        a_valid = 1; a_value = stim_v[2]; a_ref = stim_r[2]; a_clear = 1;
        @(negedge clk);
        a_valid = 0; a_clear = 0;
        checks++;
        if (a_busy !== 0 || a_ready !== 0 || a_done !== 0 || a_topk_value !== '0 || a_topk_ref !== '0 ||
            a_topk_count !== '0 || a_entry_count !== '0)
            $display("FAIL clear_abort: busy=%b ready=%b cnt=%0d ec=%0d val=%h required all 0",
                     a_busy, a_ready, a_topk_count, a_entry_count, a_topk_value);
        else passes++;
    endtask

    task automatic test_start_ignored_and_rst();
        load_stream6();
        sb_q.push_back(model(1'b0, 4, 6));
        start_a(1'b0);
        feed_a(0, 3, 1'b0);
        a_start = 1; a_find_max = 1;
        @(negedge clk);
        a_start = 0;
        checks++;
        if (a_busy !== 1 || a_topk_count !== 3'd3 || a_entry_count !== 9'd3)
            $display("FAIL start_ignored: busy=%b cnt=%0d ec=%0d required 1/3/3", a_busy, a_topk_count, a_entry_count);
        else passes++;
        feed_a(3, 6, 1'b1);
        check_result_a("after_start_pulse");

        start_a(1'b0);
        feed_a(0, 2, 1'b0);
        rst = 1;
        #1;
        checks++;
        if (a_busy !== 0 || a_ready !== 0 || a_topk_value !== '0 || a_topk_ref !== '0 ||
            a_topk_count !== '0 || a_entry_count !== '0)
            $display("FAIL async_rst: busy=%b cnt=%0d ec=%0d val=%h required all 0",
                     a_busy, a_topk_count, a_entry_count, a_topk_value);
        else passes++;
        @(negedge clk);
        rst = 0;
        stim_v[0] = 48'hFFFF_FFFF_FFF0; stim_r[0] = 8'd200;
        sb_q.push_back(model(1'b1, 4, 1));
        start_a(1'b1);
        feed_a(0, 1, 1'b1);
        check_result_a("single_after_rst");
    endtask

    task automatic test_k1_random();
        exp_t e;
        for (int j = 0; j < 256; j++) begin
            stim_v[j] = AW'($urandom_range(0, 15));
            stim_r[j] = RW'(255 - j);
        end
        stim_v[17] = 48'h8000_0000_0000;
        sb_q.push_back(model(1'b0, 1, 256));
        @(negedge clk);
        b_start = 1; b_find_max = 0;
        @(negedge clk);
        b_start = 0; b_find_max = 1;
        for (int j = 0; j < 256; j++) begin
            if ($urandom_range(0, 3) == 0) begin
                b_valid = 0;
                @(negedge clk);
            end
            b_valid = 1; b_value = stim_v[j]; b_ref = stim_r[j]; b_last = (j == 255);
            @(negedge clk);
        end
        b_valid = 0; b_last = 0;
        e = sb_q.pop_front();
        checks++;
        if (b_done !== 1'b1) $display("FAIL k1_done: got %b required 1", b_done);
        else passes++;
        checks++;
        if (b_topk_value !== e.v[AW-1:0] || b_topk_ref !== e.r[RW-1:0])
            $display("FAIL k1_slot0: got %0d/%0d required %0d/%0d", b_topk_value, b_topk_ref, e.v[AW-1:0], e.r[RW-1:0]);
        else passes++;
        checks++;
        if (b_topk_count !== 1'b1 || b_entry_count !== e.ec)
            $display("FAIL k1_counts: cnt=%0d ec=%0d required 1/%0d", b_topk_count, b_entry_count, e.ec);
        else passes++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_min_mode();
        test_max_mode();
        test_partial();
        test_clear();
        test_start_ignored_and_rst();
        test_k1_random();
        checks++;
        if (sb_q.size() != 0) $display("FAIL scoreboard_drain: %0d left, required 0", sb_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
